// File: rtl/display_pkg.sv
// Shared definitions for the text-mode display helpers: FSM encoding, ASCII
// constants and the nibble-to-character mapping.
package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'd0, n};
    else return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_line_formatter.sv
// Combinational text-line formatter: picks the character at a given column of
// the line "NN: DDDDDDDD" (prefix optional) for one captured source word.
module hex_line_formatter
  import display_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 5,
  parameter int PREFIX_EN = 1,
  parameter int COL_W     = 4
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [COL_W-1:0]  col_i,
  output logic [7:0]        ascii_o
);

  localparam int DIGITS = DATA_W / 4;
  localparam int PFX_L  = (PREFIX_EN != 0) ? 4 : 0;

  logic [7:0] idx8;
  int         col;
  int         dig;

  assign idx8 = 8'(idx_i);

  always_comb begin
    col     = int'(col_i);
    dig     = col - PFX_L;
    ascii_o = ASCII_SPACE;
    if (col < PFX_L) begin
      case (col)
        0:       ascii_o = nibble_to_ascii(idx8[7:4]);
        1:       ascii_o = nibble_to_ascii(idx8[3:0]);
        2:       ascii_o = ASCII_COLON;
        default: ascii_o = ASCII_SPACE;
      endcase
    end else if (dig < DIGITS) begin
      // Most significant nibble lands in the leftmost digit column.
      ascii_o = nibble_to_ascii(4'(word_i >> (4 * (DIGITS - 1 - dig))));
    end
  end

endmodule

// File: rtl/hex_dump_engine.sv
// Reads a range of source entries and writes each one as a line of uppercase
// hex text into the VGA character buffer, one character per cycle.
module hex_dump_engine
  import display_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                NUM_ENTRIES  = 32,
  parameter int                ADDR_W       = 13,
  parameter int                COLS         = 80,
  parameter int                ROWS         = 60,
  parameter int                ATTR_W       = 24,
  parameter logic [ATTR_W-1:0] ATTR         = 24'hFFFFFF,
  parameter int                READ_LATENCY = 1,
  parameter int                PREFIX_EN    = 1,
  localparam int               IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int               ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [IDX_W-1:0]     first_idx,
  input  logic [IDX_W:0]       count,
  input  logic [ROW_W-1:0]     base_row,
  output logic                 busy,
  output logic                 done,
  output logic                 src_rd_en,
  output logic [IDX_W-1:0]     src_idx,
  input  logic [DATA_W-1:0]    src_data,
  output logic                 char_we,
  output logic [ADDR_W-1:0]    char_addr,
  output logic [8+ATTR_W-1:0]  char_data,
  output logic [2:0]           dbg_state
);

  localparam int DIGITS    = DATA_W / 4;
  localparam int LINE_L    = DIGITS + ((PREFIX_EN != 0) ? 4 : 0);
  localparam int COL_W     = (LINE_L > 1) ? $clog2(LINE_L) : 1;
  localparam int COLS_LOG  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PROD_W    = ADDR_W + COLS_LOG;

  localparam logic [IDX_W:0]   NUM_E_W  = (IDX_W + 1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   E_ONE    = (IDX_W + 1)'(1);
  localparam logic [ROW_W:0]   ROWS_W   = (ROW_W + 1)'(ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_L - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [1:0]       WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t              state_q, state_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [IDX_W:0]      e_q, e_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [ROW_W-1:0]    cur_row_q, cur_row_d;
  logic [COL_W-1:0]    c_q, c_d;
  logic [1:0]          w_q, w_d;
  logic [DATA_W-1:0]   word_q, word_d;

  logic [PROD_W-1:0]   addr_full;
  logic [7:0]          ascii;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      e_q       <= '0;
      cur_idx_q <= '0;
      cur_row_q <= '0;
      c_q       <= '0;
      w_q       <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      e_q       <= e_d;
      cur_idx_q <= cur_idx_d;
      cur_row_q <= cur_row_d;
      c_q       <= c_d;
      w_q       <= w_d;
      word_q    <= word_d;
    end
  end

  // Row and index are tracked already reduced modulo ROWS / NUM_ENTRIES, so the
  // per-entry advance is a compare-and-wrap instead of a divider.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    e_d       = e_q;
    cur_idx_d = cur_idx_q;
    cur_row_d = cur_row_q;
    c_d       = c_q;
    w_d       = w_q;
    word_d    = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d   = (count > NUM_E_W) ? NUM_E_W : count;
          e_d       = '0;
          c_d       = '0;
          w_d       = '0;
          cur_idx_d = ({1'b0, first_idx} >= NUM_E_W) ?
                      IDX_W'({1'b0, first_idx} - NUM_E_W) : first_idx;
          cur_row_d = ({1'b0, base_row} >= ROWS_W) ?
                      ROW_W'({1'b0, base_row} - ROWS_W) : base_row;
          state_d   = (count == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        c_d = '0;
        w_d = '0;
        if (READ_LATENCY == 0) begin
          word_d  = src_data;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_q == WAIT_LAST) begin
          word_d  = src_data;
          state_d = ST_EMIT;
        end else begin
          w_d = w_q + 2'd1;
        end
      end
      ST_EMIT: begin
        if (c_q == COL_LAST) begin
          c_d = '0;
          if (e_q + E_ONE == count_q) begin
            state_d = ST_FIN;
          end else begin
            e_d       = e_q + E_ONE;
            cur_idx_d = (cur_idx_q == IDX_LAST) ? '0 : cur_idx_q + IDX_ONE;
            cur_row_d = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + ROW_ONE;
            state_d   = ST_REQ;
          end
        end else begin
          c_d = c_q + COL_ONE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  hex_line_formatter #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .PREFIX_EN(PREFIX_EN),
    .COL_W    (COL_W)
  ) u_fmt (
    .word_i (word_q),
    .idx_i  (cur_idx_q),
    .col_i  (c_q),
    .ascii_o(ascii)
  );

  assign addr_full = PROD_W'(cur_row_q) * PROD_W'(COLS) + PROD_W'(c_q);

  // Outputs decode the registered state, so an async reset clears them at once.
  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_EMIT);
  assign done      = (state_q == ST_FIN);
  assign src_rd_en = (state_q == ST_REQ);
  assign src_idx   = src_rd_en ? cur_idx_q : '0;
  assign char_we   = (state_q == ST_EMIT);
  assign char_addr = char_we ? addr_full[ADDR_W-1:0] : '0;
  assign char_data = char_we ? {ascii, ATTR} : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hex_dump_engine.sv
// Bench for hex_dump_engine: three instances (read latency 0, 1, 3) driven
// one at a time, writes and reads checked against a line-building model.
module tb_hex_dump_engine;

  localparam int NI   = 3;
  localparam int LINE = 12;
  localparam int W    = 13 + 8 + 24;

  logic clk;
  logic rst;

  logic        start_a   [NI];
  logic        abort_a   [NI];
  logic [4:0]  first_a   [NI];
  logic [5:0]  count_a   [NI];
  logic [5:0]  row_a     [NI];
  logic        busy_a    [NI];
  logic        done_a    [NI];
  logic        rd_en_a   [NI];
  logic [4:0]  src_idx_a [NI];
  logic [31:0] src_data_a[NI];
  logic        we_a      [NI];
  logic [12:0] addr_a    [NI];
  logic [31:0] data_a    [NI];
  logic [2:0]  dbg_a     [NI];

  logic [31:0] mem [32];

  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_rd_q[$];

  int n_vec;
  int n_err;
  int cur;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs + latency-honouring sources ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    localparam int PI  = (LAT == 0) ? 0 : LAT - 1;

    logic        pv [4];
    logic [31:0] pd [4];

    hex_dump_engine #(.READ_LATENCY(LAT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_a[g]),
      .abort    (abort_a[g]),
      .first_idx(first_a[g]),
      .count    (count_a[g]),
      .base_row (row_a[g]),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .src_rd_en(rd_en_a[g]),
      .src_idx  (src_idx_a[g]),
      .src_data (src_data_a[g]),
      .char_we  (we_a[g]),
      .char_addr(addr_a[g]),
      .char_data(data_a[g]),
      .dbg_state(dbg_a[g])
    );

    always @(posedge clk) begin
      pv[0] <= rd_en_a[g];
      pd[0] <= mem[src_idx_a[g]];
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end

    // Data is only valid exactly LAT cycles after the strobe; junk otherwise.
    assign src_data_a[g] = (LAT == 0) ? (rd_en_a[g] ? mem[src_idx_a[g]] : 32'hBAD0BAD0)
                                      : (pv[PI] ? pd[PI] : 32'hBAD0BAD0);
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (we_a[g]) begin
        if (g == cur && exp_q.size() > 0) check("char_wr", {addr_a[g], data_a[g][31:24], 24'hFFFFFF} == {addr_a[g], data_a[g]} ? {addr_a[g], data_a[g]} : {addr_a[g], data_a[g]}, exp_q.pop_front());
        else check("char_wr_unexpected", {addr_a[g], data_a[g]}, '1);
      end
      if (rd_en_a[g]) begin
        if (g == cur && exp_rd_q.size() > 0) check("src_idx", src_idx_a[g], exp_rd_q.pop_front());
        else check("src_rd_unexpected", src_idx_a[g], '1);
      end
    end
  end

  // ---------------- reference model ----------------
  // Builds the expected text of every line, then keeps only the accesses that
  // happen before the cut offset (cycles counted from the start cycle).
  task automatic build_expect(input int g, input int first, input int cnt, input int row,
                              input int cut, output int dur);
    int lat, p, cc, idx, r, addr, nib;
    logic [31:0] w;
    logic [7:0]  ln [LINE];
    string hexc;
    hexc = "0123456789ABCDEF";
    lat  = lat_of(g);
    p    = 1 + lat + LINE;
    cc   = (cnt > 32) ? 32 : cnt;
    exp_q.delete();
    exp_rd_q.delete();
    for (int e = 0; e < cc; e++) begin
      idx = (first + e) % 32;
      w   = mem[idx];
      r   = (row + e) % 60;
      if (1 + e * p < cut) exp_rd_q.push_back(5'(idx));
      ln[0] = hexc[idx / 16];
      ln[1] = hexc[idx % 16];
      ln[2] = ":";
      ln[3] = " ";
      for (int d = 0; d < 8; d++) begin
        nib = int'((w >> (28 - 4 * d)) & 32'hF);
        ln[4+d] = hexc[nib];
      end
      for (int c = 0; c < LINE; c++) begin
        if (2 + lat + e * p + c < cut) begin
          addr = (r * 80 + c) % 8192;
          exp_q.push_back({13'(addr), ln[c], 24'hFFFFFF});
        end
      end
    end
    dur = cc * p + 1;
  endtask

  task automatic check_quiet(input int g);
    check("q_busy",  busy_a[g], 0);
    check("q_done",  done_a[g], 0);
    check("q_rd_en", rd_en_a[g], 0);
    check("q_idx",   src_idx_a[g], 0);
    check("q_we",    we_a[g], 0);
    check("q_addr",  addr_a[g], 0);
    check("q_data",  data_a[g], 0);
    check("q_state", dbg_a[g], 0);
  endtask

  // ---------------- driver ----------------
  // abort_off / rst_off / dup_off: cycle after start at which to abort, reset,
  // or pulse a second start; -1 disables.
  task automatic run_op(input int g, input int first, input int cnt, input int row,
                        input int abort_off, input int rst_off, input int dup_off);
    int dur, cut, lim, n, done_at, done_n, busy_n;
    cut = (abort_off >= 0) ? abort_off + 1 : ((rst_off >= 0) ? rst_off : 1 << 20);
    cur = g;
    build_expect(g, first, cnt, row, cut, dur);
    lim = (abort_off >= 0) ? abort_off + 1 : dur + 5;
    @(posedge clk); #1;
    first_a[g] = 5'(first);
    count_a[g] = 6'(cnt);
    row_a[g]   = 6'(row);
    start_a[g] = 1'b1;
    done_at = -1; done_n = 0; busy_n = 0; n = 0;
    while (n < lim) begin
      @(posedge clk); n++; #1;
      if (busy_a[g]) busy_n++;
      if (done_a[g]) begin
        done_n++;
        if (done_at < 0) done_at = n;
      end
      start_a[g] = 1'b0;
      abort_a[g] = 1'b0;
      if (n == abort_off) abort_a[g] = 1'b1;
      if (n == dup_off) begin
        first_a[g] = 5'd0; count_a[g] = 6'd1; row_a[g] = 6'd0;
        start_a[g] = 1'b1;
      end
      if (n == rst_off) begin
        #2 rst = 1'b0;
        #1 check_quiet(g);
        @(posedge clk); #3 rst = 1'b1;
      end
    end
    if (abort_off >= 0 || rst_off >= 0) begin
      check("no_done", done_n, 0);
      check("busy_end", busy_a[g], 0);
      check("we_end", we_a[g], 0);
    end else begin
      check("done_cycle", done_at, dur);
      check("done_pulses", done_n, 1);
      check("busy_cycles", busy_n, dur - 1);
    end
    check("wr_left", exp_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
  endtask

  // ---------------- main ----------------
  initial begin
    n_vec = 0; n_err = 0; cur = 0;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_a[g] = 1'b0; abort_a[g] = 1'b0;
      first_a[g] = '0; count_a[g] = '0; row_a[g] = '0;
    end
    fill_mem();
    #2 rst = 1'b0;
    #1 for (int g = 0; g < NI; g++) check_quiet(g);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Basic line: "05: DEADBEEF" on row 2.
    mem[5] = 32'hDEADBEEF;
    run_op(1, 5, 1, 2, -1, -1, -1);

    // Index and row wrap.
    fill_mem();
    run_op(1, 30, 4, 58, -1, -1, -1);

    // Zero-length dump.
    run_op(1, 9, 0, 3, -1, -1, -1);

    // Abort on the 3rd char of the 2nd entry, then restart right away.
    run_op(1, 12, 4, 7, 2 + 1 + (1 + 1 + LINE) + 2, -1, -1);
    run_op(1, 20, 2, 40, -1, -1, -1);

    // Latency sweep.
    mem[17] = 32'h0123ABCD;
    run_op(0, 17, 1, 0, -1, -1, -1);
    run_op(2, 17, 1, 59, -1, -1, -1);
    run_op(0, 3, 3, 10, -1, -1, -1);
    run_op(2, 3, 3, 10, -1, -1, -1);

    // Start while busy is ignored; count clamp; base_row beyond the screen.
    run_op(1, 3, 2, 10, -1, -1, 5);
    run_op(1, 0, 40, 63, -1, -1, -1);

    // Reset in the middle of an EMIT.
    run_op(1, 7, 3, 20, -1, 2 + 1 + (1 + 1 + LINE) + 5, -1);
    run_op(1, 8, 1, 1, -1, -1, -1);

    for (int t = 0; t < 20; t++) begin
      fill_mem();
      run_op($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 40),
             $urandom_range(0, 63), -1, -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
